irq_ctrl: RTL

- Parametrised interrupt controller between N peripheral interrupt lines plus one NMI line and the 6502 core's `nmi`/`irq` inputs.
- Generalises the core's single irq/nmi event logic: per-channel synchronisers, edge/level mode, masking, fixed priority and optional per-channel vectoring.
- The core reads the vector from `vec_addr` on interrupt entry.
- Software configures the block through a small 8-bit register window on the CPU data bus.

---
 rtl/irq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the 6502 core: synchronised IRQ/NMI sources,
// edge/level pending logic, masking, fixed lowest-index priority and optional vectoring.
module irq_ctrl #(
  parameter int unsigned N_IRQ       = 8,
  parameter logic [7:0]  EDGE_MASK   = 8'h00,
  parameter logic [7:0]  MASK_RST    = 8'h00,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VECTOR  = 16'hfffa,
  parameter logic [15:0] IRQ_VECTOR  = 16'hfffe,
  parameter logic [15:0] VEC_BASE    = 16'hffe0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             nmi_src,
  output logic             irq_o,
  output logic             nmi_o,
  input  logic             int_ack,
  output logic [15:0]      vec_addr,
  input  logic             reg_cs,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata
);

  localparam int unsigned CH_W = 8;
  localparam logic [CH_W-1:0] CH_VALID = CH_W'((9'(1) << N_IRQ) - 9'(1));
  localparam logic [CH_W-1:0] EDGE_CH  = EDGE_MASK & CH_VALID;

  logic [CH_W-1:0]        src_pad;
  logic [CH_W-1:0]        irq_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [CH_W-1:0]        irq_hist;
  logic                   nmi_hist;

  logic [CH_W-1:0] edge_pend_q, edge_pend_d;
  logic [CH_W-1:0] mask_q, status_q, status_d;
  logic            ctrl_q, nmi_pend_q, nmi_pend_d, irq_q;

  logic [CH_W-1:0] irq_lvl, irq_rise, pend, act, clr;
  logic [2:0]      win_id;
  logic            any_act, nmi_rise, ack_irq;
  logic            wr_pend, wr_mask, wr_ctrl;

  always_comb begin
    src_pad = '0;
    src_pad[N_IRQ-1:0] = irq_src;
  end

  assign wr_pend = reg_cs && reg_we && (reg_addr == 2'd0);
  assign wr_mask = reg_cs && reg_we && (reg_addr == 2'd1);
  assign wr_ctrl = reg_cs && reg_we && (reg_addr == 2'd3);

  // Level channels follow the synchroniser directly; edge channels latch a rise.
  assign irq_lvl  = irq_sync[SYNC_STAGES-1];
  assign irq_rise = irq_lvl & ~irq_hist & EDGE_CH;
  assign nmi_rise = nmi_sync[SYNC_STAGES-1] & ~nmi_hist;
  assign pend     = (edge_pend_q & EDGE_CH) | (irq_lvl & ~EDGE_CH & CH_VALID);
  assign act      = pend & mask_q;
  assign any_act  = |act;
  assign ack_irq  = int_ack && !nmi_pend_q && any_act;

  always_comb begin
    win_id = '0;
    for (int i = CH_W - 1; i >= 0; i--) begin
      if (act[i]) win_id = 3'(i);
    end
  end

  // Next-state for pending, NMI and STATUS; a new set beats a same-cycle clear.
  always_comb begin
    clr         = '0;
    status_d    = status_q;
    if (wr_pend) clr = clr | reg_wdata;
    if (ack_irq) clr = clr | (CH_W'(1) << win_id);
    edge_pend_d = ((edge_pend_q & ~clr) | irq_rise) & EDGE_CH;
    nmi_pend_d  = (nmi_pend_q && !int_ack) || nmi_rise;
    if (int_ack) begin
      if (nmi_pend_q)   status_d = 8'hC0;
      else if (any_act) status_d = {1'b1, 4'b0000, win_id};
      else              status_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) irq_sync[s] <= '0;
      nmi_sync    <= '0;
      irq_hist    <= '0;
      nmi_hist    <= 1'b0;
      edge_pend_q <= '0;
      nmi_pend_q  <= 1'b0;
      mask_q      <= MASK_RST;
      status_q    <= '0;
      ctrl_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_sync[0] <= src_pad;
      nmi_sync[0] <= nmi_src;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        irq_sync[s] <= irq_sync[s-1];
        nmi_sync[s] <= nmi_sync[s-1];
      end
      irq_hist    <= irq_lvl;
      nmi_hist    <= nmi_sync[SYNC_STAGES-1];
      edge_pend_q <= edge_pend_d;
      nmi_pend_q  <= nmi_pend_d;
      status_q    <= status_d;
      irq_q       <= any_act;
      if (wr_mask) mask_q <= reg_wdata;
      if (wr_ctrl) ctrl_q <= reg_wdata[0];
    end
  end

  assign irq_o = irq_q;
  assign nmi_o = nmi_pend_q;

  always_comb begin
    vec_addr = IRQ_VECTOR;
    if (nmi_pend_q)            vec_addr = NMI_VECTOR;
    else if (ctrl_q && any_act) vec_addr = VEC_BASE + 16'({win_id, 1'b0});
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata = pend;
      2'd1: reg_rdata = mask_q;
      2'd2: reg_rdata = status_q;
      2'd3: reg_rdata = {7'b0000000, ctrl_q};
      default: reg_rdata = '0;
    endcase
  end

endmodule
